// File: rtl/axi_lite_arbiter.sv
// Purpose : shares one AXI-Lite slave port between two AXI-Lite masters, one transaction at a time.
// Latency : one cycle from a request being seen in IDLE to forwarding; at least one IDLE cycle between transactions.
// Backpr. : slave readies pass to the owning master only; the other master sees no ready and keeps its request pending.
//
// Ports:
//   aclk, arst_n            clock, synchronous active-low reset
//   m_AW*/m_W*/m_AR*        per-master request channels (index 0 = M0, index 1 = M1)
//   m_B*/m_R*               per-master response channels
//   s_AW*/s_W*/s_AR*        shared slave request channels
//   s_B*/s_R*               shared slave response channels
//   grant                   one-hot owner of the slave port, 0 when idle
//   busy                    high whenever a transaction is in progress
module axi_lite_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic                        aclk,
  input  logic                        arst_n,

  // master write-address channels
  input  logic [1:0]                  m_AWValid,
  input  logic [1:0][ADDR_W-1:0]      m_AWAddr,
  input  logic [1:0][ID_W-1:0]        m_AWID,
  input  logic [1:0][2:0]             m_AWProt,
  output logic [1:0]                  m_AWReady,

  // master write-data channels
  input  logic [1:0]                  m_WValid,
  input  logic [1:0][DATA_W-1:0]      m_WData,
  input  logic [1:0][DATA_W/8-1:0]    m_WStrb,
  output logic [1:0]                  m_WReady,

  // master write-response channels
  output logic [1:0]                  m_BValid,
  output logic [1:0][ID_W-1:0]        m_BID,
  output logic [1:0][1:0]             m_BResp,
  input  logic [1:0]                  m_BReady,

  // master read-address channels
  input  logic [1:0]                  m_ARValid,
  input  logic [1:0][ADDR_W-1:0]      m_ARAddr,
  input  logic [1:0][ID_W-1:0]        m_ARID,
  input  logic [1:0][2:0]             m_ARProt,
  output logic [1:0]                  m_ARReady,

  // master read-data channels
  output logic [1:0]                  m_RValid,
  output logic [1:0][DATA_W-1:0]      m_RData,
  output logic [1:0][ID_W-1:0]        m_RID,
  output logic [1:0][1:0]             m_RResp,
  input  logic [1:0]                  m_RReady,

  // slave write-address channel
  output logic                        s_AWValid,
  output logic [ADDR_W-1:0]           s_AWAddr,
  output logic [ID_W-1:0]             s_AWID,
  output logic [2:0]                  s_AWProt,
  input  logic                        s_AWReady,

  // slave write-data channel
  output logic                        s_WValid,
  output logic [DATA_W-1:0]           s_WData,
  output logic [DATA_W/8-1:0]         s_WStrb,
  input  logic                        s_WReady,

  // slave write-response channel
  input  logic                        s_BValid,
  input  logic [ID_W-1:0]             s_BID,
  input  logic [1:0]                  s_BResp,
  output logic                        s_BReady,

  // slave read-address channel
  output logic                        s_ARValid,
  output logic [ADDR_W-1:0]           s_ARAddr,
  output logic [ID_W-1:0]             s_ARID,
  output logic [2:0]                  s_ARProt,
  input  logic                        s_ARReady,

  // slave read-data channel
  input  logic                        s_RValid,
  input  logic [DATA_W-1:0]           s_RData,
  input  logic [ID_W-1:0]             s_RID,
  input  logic [1:0]                  s_RResp,
  output logic                        s_RReady,

  // status
  output logic [1:0]                  grant,
  output logic                        busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       rr_ptr_q, rr_ptr_d;     // master preferred when both request
  logic       aw_done_q, aw_done_d;   // AW accepted by the slave for this write
  logic       w_done_q, w_done_d;     // W accepted by the slave for this write

  logic [1:0] req;
  logic       gidx;                   // index of the granted master
  logic       pick;
  logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign req  = m_AWValid | m_ARValid;
  assign gidx = grant_q[1];

  // Handshakes are evaluated on the slave side; the gated valids/readies
  // below guarantee they only fire in the matching state.
  assign aw_hs = s_AWValid & s_AWReady;
  assign w_hs  = s_WValid  & s_WReady;
  assign b_hs  = s_BValid  & s_BReady;
  assign ar_hs = s_ARValid & s_ARReady;
  assign r_hs  = s_RValid  & s_RReady;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      rr_ptr_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    pick      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          // Contention resolved by the round-robin pointer; a lone requester
          // is always taken.
          pick    = (req == 2'b11) ? rr_ptr_q : req[1];
          grant_d = pick ? 2'b10 : 2'b01;
          // Write wins over read inside the chosen master.
          state_d = m_AWValid[pick] ? WR_REQ : RD_REQ;
        end
      end

      WR_REQ: begin
        // AW and W may complete in any order or together; leave as soon as
        // both are accepted so WR_RESP follows the last handshake directly.
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q  | w_hs;
        end
      end

      WR_RESP: begin
        if (b_hs) begin
          state_d  = IDLE;
          grant_d  = 2'b00;
          rr_ptr_d = ~gidx;
        end
      end

      RD_REQ: begin
        if (ar_hs) begin
          state_d = RD_RESP;
        end
      end

      RD_RESP: begin
        if (r_hs) begin
          state_d  = IDLE;
          grant_d  = 2'b00;
          rr_ptr_d = ~gidx;
        end
      end

      default: begin
        state_d  = IDLE;
        grant_d  = 2'b00;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // Payload fields are steered unconditionally; only valids and readies are
  // gated by state and ownership. Slave-side valids depend only on state and
  // master valids, never on any master ready.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_AWAddr  = m_AWAddr[gidx];
    s_AWID    = m_AWID[gidx];
    s_AWProt  = m_AWProt[gidx];
    s_WData   = m_WData[gidx];
    s_WStrb   = m_WStrb[gidx];
    s_ARAddr  = m_ARAddr[gidx];
    s_ARID    = m_ARID[gidx];
    s_ARProt  = m_ARProt[gidx];

    for (int i = 0; i < 2; i++) begin
      m_BID[i]   = s_BID;
      m_BResp[i] = s_BResp;
      m_RData[i] = s_RData;
      m_RID[i]   = s_RID;
      m_RResp[i] = s_RResp;
    end

    s_AWValid = 1'b0;
    s_WValid  = 1'b0;
    s_ARValid = 1'b0;
    s_BReady  = 1'b0;
    s_RReady  = 1'b0;
    m_AWReady = 2'b00;
    m_WReady  = 2'b00;
    m_ARReady = 2'b00;
    m_BValid  = 2'b00;
    m_RValid  = 2'b00;

    unique case (state_q)
      WR_REQ: begin
        // A channel that has already handshaken is hidden from both sides so
        // the slave never sees a second beat.
        s_AWValid       = m_AWValid[gidx] & ~aw_done_q;
        s_WValid        = m_WValid[gidx]  & ~w_done_q;
        m_AWReady[gidx] = s_AWReady & ~aw_done_q;
        m_WReady[gidx]  = s_WReady  & ~w_done_q;
      end
      WR_RESP: begin
        m_BValid[gidx] = s_BValid;
        s_BReady       = m_BReady[gidx];
      end
      RD_REQ: begin
        s_ARValid       = m_ARValid[gidx];
        m_ARReady[gidx] = s_ARReady;
      end
      RD_RESP: begin
        m_RValid[gidx] = s_RValid;
        s_RReady       = m_RReady[gidx];
      end
      default: begin
      end
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_axi_lite_arbiter.sv
module tb_axi_lite_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int SW = DW / 8;
  localparam logic [63:0] RD_SALT = 64'hA5A5_5A5A_0F0F_F0F0;

  logic aclk = 1'b0;
  logic arst_n;
  always #5 aclk = ~aclk;

  logic [1:0]          m_AWValid, m_AWReady, m_WValid, m_WReady, m_BValid, m_BReady;
  logic [1:0]          m_ARValid, m_ARReady, m_RValid, m_RReady;
  logic [1:0][AW-1:0]  m_AWAddr, m_ARAddr;
  logic [1:0][IW-1:0]  m_AWID, m_ARID, m_BID, m_RID;
  logic [1:0][2:0]     m_AWProt, m_ARProt;
  logic [1:0][DW-1:0]  m_WData, m_RData;
  logic [1:0][SW-1:0]  m_WStrb;
  logic [1:0][1:0]     m_BResp, m_RResp;

  logic          s_AWValid, s_AWReady, s_WValid, s_WReady, s_BValid, s_BReady;
  logic          s_ARValid, s_ARReady, s_RValid, s_RReady;
  logic [AW-1:0] s_AWAddr, s_ARAddr;
  logic [IW-1:0] s_AWID, s_ARID, s_BID, s_RID;
  logic [2:0]    s_AWProt, s_ARProt;
  logic [DW-1:0] s_WData, s_RData;
  logic [SW-1:0] s_WStrb;
  logic [1:0]    s_BResp, s_RResp;
  logic [1:0]    grant;
  logic          busy;

  axi_lite_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .aclk(aclk), .arst_n(arst_n),
    .m_AWValid(m_AWValid), .m_AWAddr(m_AWAddr), .m_AWID(m_AWID), .m_AWProt(m_AWProt), .m_AWReady(m_AWReady),
    .m_WValid(m_WValid), .m_WData(m_WData), .m_WStrb(m_WStrb), .m_WReady(m_WReady),
    .m_BValid(m_BValid), .m_BID(m_BID), .m_BResp(m_BResp), .m_BReady(m_BReady),
    .m_ARValid(m_ARValid), .m_ARAddr(m_ARAddr), .m_ARID(m_ARID), .m_ARProt(m_ARProt), .m_ARReady(m_ARReady),
    .m_RValid(m_RValid), .m_RData(m_RData), .m_RID(m_RID), .m_RResp(m_RResp), .m_RReady(m_RReady),
    .s_AWValid(s_AWValid), .s_AWAddr(s_AWAddr), .s_AWID(s_AWID), .s_AWProt(s_AWProt), .s_AWReady(s_AWReady),
    .s_WValid(s_WValid), .s_WData(s_WData), .s_WStrb(s_WStrb), .s_WReady(s_WReady),
    .s_BValid(s_BValid), .s_BID(s_BID), .s_BResp(s_BResp), .s_BReady(s_BReady),
    .s_ARValid(s_ARValid), .s_ARAddr(s_ARAddr), .s_ARID(s_ARID), .s_ARProt(s_ARProt), .s_ARReady(s_ARReady),
    .s_RValid(s_RValid), .s_RData(s_RData), .s_RID(s_RID), .s_RResp(s_RResp), .s_RReady(s_RReady),
    .grant(grant), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

  task automatic drive_idle();
    m_AWValid = '0; m_AWAddr = '0; m_AWID = '0; m_AWProt = '0;
    m_WValid = '0; m_WData = '0; m_WStrb = '0; m_BReady = '0;
    m_ARValid = '0; m_ARAddr = '0; m_ARID = '0; m_ARProt = '0; m_RReady = '0;
    s_AWReady = 1'b0; s_WReady = 1'b0; s_ARReady = 1'b0;
    s_BValid = 1'b0; s_BID = '0; s_BResp = '0;
    s_RValid = 1'b0; s_RData = '0; s_RID = '0; s_RResp = '0;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    drive_idle();
    arst_n = 1'b0;
    repeat (2) @(negedge aclk);
    arst_n = 1'b1;
  endtask

  // Reference model: one owner at a time, round-robin on contention,
  // write before read inside the owner, one idle cycle between transactions.
  logic        mbusy, mown, mwr, mawd, mwd, mard, mrr;
  logic [1:0]  wr_act, rd_act, ma_aw, ma_w, ma_ar, req, exp_g;
  logic        wresp, rresp, fin;
  logic [63:0] wr_addr[2], wr_data[2], rd_addr[2];
  logic [7:0]  wr_strb[2];
  logic [3:0]  wr_id[2], rd_id[2];
  logic [2:0]  wr_prot[2], rd_prot[2];
  int          wr_gap[2], rd_gap[2];
  int          n_wr_iss, n_wr_done, n_rd_iss, n_rd_done;
  // behavioural slave
  logic        sl_aw_got, sl_w_got, sl_b_pend, sl_r_pend;
  logic [3:0]  sl_b_id, sl_r_id;
  logic [1:0]  sl_b_resp, sl_r_resp;
  logic [63:0] sl_r_data;

  initial begin
    arst_n = 1'b0;
    drive_idle();
    do_reset();

    // ---- reset state ----
    #1;
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_s_valids", {s_AWValid, s_WValid, s_ARValid, s_BReady, s_RReady}, 5'b0);
    check("rst_m_signals", {m_AWReady, m_WReady, m_ARReady, m_BValid, m_RValid}, 10'b0);

    // ---- M0 single write ----
    @(negedge aclk);
    m_AWValid = 2'b01; m_AWAddr[0] = 64'h10; m_AWID[0] = 4'd3; m_AWProt[0] = 3'd2;
    m_WValid = 2'b01; m_WData[0] = 64'hDEADBEEF; m_WStrb[0] = 8'hFF;
    s_AWReady = 1'b1; s_WReady = 1'b1;
    #1;
    check("wr_lat_awvalid", s_AWValid, 1'b0);
    check("wr_lat_awready", m_AWReady, 2'b00);
    @(negedge aclk); #1;
    check("wr_grant", grant, 2'b01);
    check("wr_s_awvalid", s_AWValid, 1'b1);
    check("wr_s_awaddr", s_AWAddr, 64'h10);
    check("wr_s_awid", s_AWID, 4'd3);
    check("wr_s_awprot", s_AWProt, 3'd2);
    check("wr_s_wdata", s_WData, 64'hDEADBEEF);
    check("wr_s_wstrb", s_WStrb, 8'hFF);
    check("wr_m_readies", {m_AWReady, m_WReady}, 4'b0101);
    @(negedge aclk);
    m_AWValid = 2'b00; m_WValid = 2'b00;
    s_BValid = 1'b1; s_BID = 4'd3; s_BResp = 2'd0; m_BReady = 2'b11;
    #1;
    check("wr_m_bvalid", m_BValid, 2'b01);
    check("wr_m_bid", m_BID[0], 4'd3);
    check("wr_m_bresp", m_BResp[0], 2'd0);
    check("wr_s_bready", s_BReady, 1'b1);
    check("wr_busy_resp", busy, 1'b1);
    @(negedge aclk);
    s_BValid = 1'b0; m_BReady = 2'b00;
    #1;
    check("wr_busy_done", busy, 1'b0);
    check("wr_grant_done", grant, 2'b00);

    // ---- M1 read with 3-cycle master stall ----
    @(negedge aclk);
    m_ARValid = 2'b10; m_ARAddr[1] = 64'h80; m_ARID[1] = 4'd6; s_ARReady = 1'b1;
    #1;
    check("rd_lat_grant", grant, 2'b00);
    @(negedge aclk); #1;
    check("rd_grant", grant, 2'b10);
    check("rd_s_arvalid", s_ARValid, 1'b1);
    check("rd_s_araddr", s_ARAddr, 64'h80);
    check("rd_m_arready", m_ARReady, 2'b10);
    @(negedge aclk);
    m_ARValid = 2'b00; s_RValid = 1'b1; s_RData = 64'h1234; s_RID = 4'd6; m_RReady = 2'b00;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("rd_stall_s_rready", s_RReady, 1'b0);
      check("rd_stall_m_rvalid", m_RValid, 2'b10);
      check("rd_stall_rdata", m_RData[1], 64'h1234);
      @(negedge aclk);
    end
    m_RReady = 2'b10;
    #1;
    check("rd_s_rready", s_RReady, 1'b1);
    check("rd_m_rid", m_RID[1], 4'd6);
    @(negedge aclk);
    s_RValid = 1'b0; m_RReady = 2'b00;
    #1;
    check("rd_grant_done", grant, 2'b00);

    // ---- reset during RD_RESP ----
    @(negedge aclk);
    m_ARValid = 2'b01; m_ARAddr[0] = 64'h20;
    @(negedge aclk);
    @(negedge aclk);
    m_ARValid = 2'b00; s_RValid = 1'b1; s_RData = 64'h55;
    #1;
    check("rst_mid_rvalid_before", m_RValid, 2'b01);
    @(negedge aclk);
    arst_n = 1'b0;
    @(negedge aclk);
    arst_n = 1'b1;
    #1;
    check("rst_mid_grant", grant, 2'b00);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_m_signals", {m_AWReady, m_WReady, m_ARReady, m_BValid, m_RValid}, 10'b0);
    check("rst_mid_s_rready", s_RReady, 1'b0);

    // ---- randomized traffic against the reference model ----
    do_reset();
    mbusy = 0; mown = 0; mwr = 0; mawd = 0; mwd = 0; mard = 0; mrr = 0;
    wr_act = '0; rd_act = '0; ma_aw = '0; ma_w = '0; ma_ar = '0;
    n_wr_iss = 0; n_wr_done = 0; n_rd_iss = 0; n_rd_done = 0;
    sl_aw_got = 0; sl_w_got = 0; sl_b_pend = 0; sl_r_pend = 0;
    sl_b_id = '0; sl_r_id = '0; sl_b_resp = '0; sl_r_resp = '0; sl_r_data = '0;
    fin = 0;
    for (int i = 0; i < 2; i++) begin
      wr_gap[i] = 0; rd_gap[i] = 0;
      wr_addr[i] = '0; wr_data[i] = '0; rd_addr[i] = '0;
      wr_strb[i] = '0; wr_id[i] = '0; rd_id[i] = '0; wr_prot[i] = '0; rd_prot[i] = '0;
    end

    for (int cyc = 0; cyc < 8000 && !fin; cyc++) begin
      if (cyc > 0) @(negedge aclk);
      for (int i = 0; i < 2; i++) begin
        if (!wr_act[i] && cyc < 3000) begin
          if (wr_gap[i] > 0) wr_gap[i]--;
          else begin
            wr_act[i] = 1; n_wr_iss++;
            wr_addr[i] = {$urandom, $urandom}; wr_data[i] = {$urandom, $urandom};
            wr_strb[i] = 8'($urandom); wr_id[i] = 4'($urandom); wr_prot[i] = 3'($urandom);
          end
        end
        if (!rd_act[i] && cyc < 3000) begin
          if (rd_gap[i] > 0) rd_gap[i]--;
          else begin
            rd_act[i] = 1; n_rd_iss++;
            rd_addr[i] = {$urandom, $urandom}; rd_id[i] = 4'($urandom); rd_prot[i] = 3'($urandom);
          end
        end
        m_AWValid[i] = wr_act[i] & ~ma_aw[i];
        m_AWAddr[i] = wr_addr[i]; m_AWID[i] = wr_id[i]; m_AWProt[i] = wr_prot[i];
        m_WValid[i] = wr_act[i] & ~ma_w[i];
        m_WData[i] = wr_data[i]; m_WStrb[i] = wr_strb[i];
        m_ARValid[i] = rd_act[i] & ~ma_ar[i];
        m_ARAddr[i] = rd_addr[i]; m_ARID[i] = rd_id[i]; m_ARProt[i] = rd_prot[i];
      end
      m_BReady = 2'($urandom); m_RReady = 2'($urandom);
      s_AWReady = ($urandom_range(0, 3) != 0);
      s_WReady  = ($urandom_range(0, 3) != 0);
      s_ARReady = ($urandom_range(0, 3) != 0);
      s_BValid = sl_b_pend; s_BID = sl_b_id; s_BResp = sl_b_resp;
      s_RValid = sl_r_pend; s_RData = sl_r_data; s_RID = sl_r_id; s_RResp = sl_r_resp;
      #1;

      exp_g = mbusy ? oh(mown) : 2'b00;
      wresp = mbusy & mwr & mawd & mwd;
      rresp = mbusy & ~mwr & mard;
      check("grant", grant, exp_g);
      check("busy", busy, mbusy);
      check("s_awvalid", s_AWValid, mbusy & mwr & ~mawd);
      check("s_wvalid", s_WValid, mbusy & mwr & ~mwd);
      check("s_arvalid", s_ARValid, mbusy & ~mwr & ~mard);
      check("s_bready", s_BReady, wresp & m_BReady[mown]);
      check("s_rready", s_RReady, rresp & m_RReady[mown]);
      check("m_awready", m_AWReady, (mbusy & mwr & ~mawd & s_AWReady) ? oh(mown) : 2'b00);
      check("m_wready", m_WReady, (mbusy & mwr & ~mwd & s_WReady) ? oh(mown) : 2'b00);
      check("m_arready", m_ARReady, (mbusy & ~mwr & ~mard & s_ARReady) ? oh(mown) : 2'b00);
      check("m_bvalid", m_BValid, (wresp & s_BValid) ? oh(mown) : 2'b00);
      check("m_rvalid", m_RValid, (rresp & s_RValid) ? oh(mown) : 2'b00);

      // slave side
      if (s_BValid && s_BReady) sl_b_pend = 0;
      if (s_RValid && s_RReady) sl_r_pend = 0;
      if (s_AWValid && s_AWReady) begin
        check("aw_addr", s_AWAddr, wr_addr[mown]);
        check("aw_id", s_AWID, wr_id[mown]);
        check("aw_prot", s_AWProt, wr_prot[mown]);
        sl_aw_got = 1; sl_b_id = s_AWID; sl_b_resp = s_AWAddr[1:0]; mawd = 1;
      end
      if (s_WValid && s_WReady) begin
        check("w_data", s_WData, wr_data[mown]);
        check("w_strb", s_WStrb, wr_strb[mown]);
        sl_w_got = 1; mwd = 1;
      end
      if (sl_aw_got && sl_w_got) begin
        sl_b_pend = 1; sl_aw_got = 0; sl_w_got = 0;
      end
      if (s_ARValid && s_ARReady) begin
        check("ar_addr", s_ARAddr, rd_addr[mown]);
        check("ar_id", s_ARID, rd_id[mown]);
        check("ar_prot", s_ARProt, rd_prot[mown]);
        sl_r_pend = 1; sl_r_id = s_ARID; sl_r_data = s_ARAddr ^ RD_SALT; sl_r_resp = s_ARAddr[3:2];
        mard = 1;
      end

      // master side; req is what the masters present this cycle
      req = m_AWValid | m_ARValid;
      for (int i = 0; i < 2; i++) begin
        if (m_AWValid[i] && m_AWReady[i]) ma_aw[i] = 1;
        if (m_WValid[i] && m_WReady[i]) ma_w[i] = 1;
        if (m_ARValid[i] && m_ARReady[i]) ma_ar[i] = 1;
        if (m_BValid[i] && m_BReady[i]) begin
          check("b_id", m_BID[i], wr_id[i]);
          check("b_resp", m_BResp[i], wr_addr[i][1:0]);
          wr_act[i] = 0; ma_aw[i] = 0; ma_w[i] = 0;
          wr_gap[i] = $urandom_range(0, 3); n_wr_done++;
        end
        if (m_RValid[i] && m_RReady[i]) begin
          check("r_data", m_RData[i], rd_addr[i] ^ RD_SALT);
          check("r_id", m_RID[i], rd_id[i]);
          check("r_resp", m_RResp[i], rd_addr[i][3:2]);
          rd_act[i] = 0; ma_ar[i] = 0;
          rd_gap[i] = $urandom_range(0, 3); n_rd_done++;
        end
      end

      // model transition at the coming edge
      if (mbusy && ((wresp && s_BValid && m_BReady[mown]) || (rresp && s_RValid && m_RReady[mown]))) begin
        mbusy = 0; mrr = ~mown;
      end else if (!mbusy && req != 2'b00) begin
        mown = (req == 2'b11) ? mrr : req[1];
        mwr = m_AWValid[mown];
        mbusy = 1; mawd = 0; mwd = 0; mard = 0;
      end

      fin = (cyc >= 3000) && (wr_act == 2'b00) && (rd_act == 2'b00) && !mbusy;
    end

    check("drain_done", fin, 1'b1);
    check("wr_count", n_wr_done, n_wr_iss);
    check("rd_count", n_rd_done, n_rd_iss);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
